serial_adder: RTL and testbench

- Bit-serial ripple adder: the additive counterpart to the team's combinational subtractor cells.
- Loads two W-bit operands and a carry-in on a start request.
- Adds one bit per clock, LSB first, through a single full-adder slice and a carry flip-flop.
- Presents the W-bit sum and carry-out with a one-cycle done pulse. Used where area matters more than latency.

---
 rtl/serial_adder.sv | 131 +++++++++++++
 tb/tb_serial_adder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice plus a carry flop, LSB first, W edges per add.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module serial_adder #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   sa_q, sa_d;
  logic [W-1:0]   sb_q, sb_d;
  logic           c_q, c_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   sum_q, sum_d;
  logic           cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic           ovf_q, ovf_d;
`endif

  logic           bit_s;
  logic           carry_new;
  logic [W-1:0]   s_msb;

  always_comb begin
    state_d   = state_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    c_d       = c_q;
    cnt_d     = cnt_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d     = ovf_q;
`endif
    bit_s     = sa_q[0] ^ sb_q[0] ^ c_q;
    carry_new = (sa_q[0] & sb_q[0]) | (c_q & (sa_q[0] ^ sb_q[0]));
    // Built this way so W=1 needs no zero-width slice of sum_q.
    s_msb        = '0;
    s_msb[W-1]   = bit_s;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          c_d     = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        c_d   = carry_new;
        sum_d = (sum_q >> 1) | s_msb;
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cout_d  = carry_new;
`ifdef SERIAL_ADDER_OVF_EN
          // c_q is the carry into the MSB on this final edge.
          ovf_d   = c_q ^ carry_new;
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (W=8): vector table plus hand sequences for
// hold, ignored start, mid-run reset and back-to-back operation.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int checks;
  int errors;
  int cyc;

  serial_adder #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vcin;
    logic [W-1:0] esum;
    logic         ecout;
    logic         eovf;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  // Drive a start for one cycle, then wait for done; lat = edges after the start edge.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tcin,
                       output int lat);
    a = ta; b = tb_v; cin = tcin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    check("busy_after_start", 32'(busy), 32'd1);
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  int lat;
  logic [W-1:0] held_sum;
  logic         held_cout;
  int dcount;
  int t_prev;

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[5] = '{8'h40, 8'h10, 1'b0, 8'h50, 1'b0, 1'b0};
    vecs[6] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[7] = '{8'hA5, 8'h5B, 1'b1, 8'h01, 1'b1, 1'b0};
    vecs[8] = '{8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum",  32'(sum),  32'd0);
    check("rst_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check("rst_ovf",  32'(ovf),  32'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      do_op(vecs[i].va, vecs[i].vb, vecs[i].vcin, lat);
      check("latency", 32'(lat), 32'(W));
      check("sum", 32'(sum), 32'(vecs[i].esum));
      check("cout", 32'(cout), 32'(vecs[i].ecout));
`ifdef SERIAL_ADDER_OVF_EN
      check("ovf", 32'(ovf), 32'(vecs[i].eovf));
`endif
      check("busy_in_done", 32'(busy), 32'd1);
      @(posedge clk); #1;
      check("done_pulse_end", 32'(done), 32'd0);
      check("idle_after_done", 32'(busy), 32'd0);
      $display("vec %0d: a=%02h b=%02h cin=%0d -> sum=%02h cout=%0d lat=%0d",
               i, vecs[i].va, vecs[i].vb, vecs[i].vcin, sum, cout, lat);
    end

    // Result held while idle.
    do_op(8'h5A, 8'h3C, 1'b0, lat);
    held_sum = 8'h96; held_cout = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold_sum", 32'(sum), 32'(held_sum));
      check("hold_cout", 32'(cout), 32'(held_cout));
    end
    $display("hold: sum=%02h cout=%0d held 5 idle cycles", sum, cout);

    // Start pulsed during RUN is ignored.
    a = 8'h11; b = 8'h22; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    a = 8'hF0; b = 8'h0F; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dcount = 0;
    held_sum = 8'h00;
    for (int i = 0; i < 25; i++) begin
      if (done) begin
        dcount++;
        held_sum = sum;
        check("busy_ignore_cout", 32'(cout), 32'd0);
      end
      @(posedge clk); #1;
    end
    check("ignore_sum", 32'(held_sum), 32'h33);
    check("ignore_done_count", 32'(dcount), 32'd1);
    check("ignore_idle", 32'(busy), 32'd0);
    $display("ignore: sum=%02h done_pulses=%0d", held_sum, dcount);

    // Asynchronous reset at the 4th RUN edge.
    a = 8'h5A; b = 8'h3C; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_sum",  32'(sum),  32'd0);
    check("mid_rst_cout", 32'(cout), 32'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    dcount = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done || busy) dcount++;
    end
    check("post_rst_quiet", 32'(dcount), 32'd0);
    do_op(8'h01, 8'h01, 1'b0, lat);
    check("post_rst_latency", 32'(lat), 32'(W));
    check("post_rst_sum", 32'(sum), 32'h02);
    check("post_rst_cout", 32'(cout), 32'd0);
    $display("mid-run reset: recovered, 01+01 -> sum=%02h", sum);
    @(posedge clk); #1;

    // Start held high: one result every W+2 cycles.
    a = 8'h03; b = 8'h04; cin = 1'b0; start = 1'b1;
    t_prev = -1;
    dcount = 0;
    for (int i = 0; i < 60 && dcount < 4; i++) begin
      @(posedge clk); #1;
      if (done) begin
        check("b2b_sum", 32'(sum), 32'h07);
        if (t_prev >= 0) check("b2b_period", 32'(cyc - t_prev), 32'(W + 2));
        $display("b2b: done at cycle %0d sum=%02h", cyc, sum);
        t_prev = cyc;
        dcount++;
      end
    end
    check("b2b_done_count", 32'(dcount), 32'd4);
    start = 1'b0;
    repeat (12) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
